// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [XLEN-1:0]  ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0]  INT_MIN  = 32'h8000_0000;
  localparam logic [CNT_W-1:0] CNT_INIT = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement of a W-bit vector (pure combinational).
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  // Negate only when requested.
  always_comb begin
    if (neg_i) begin
      res_o = ~val_i + {{(W-1){1'b0}}, 1'b1};
    end else begin
      res_o = val_i;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on operand
// magnitudes, XLEN iterations, sign fix-up in a final FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          f3_q;
  logic [XLEN-1:0]     b_q;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                res_neg_q, div_zero_q, ovf_q;
  logic                busy_q, done_q;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]     a_abs_s, b_abs_s;
  logic [XLEN:0]       mul_sum_s, div_shift_s, div_diff_s;
  logic [2*XLEN-1:0]   fix_val_s, fix_neg_s;

  // Operand signedness for the incoming op; MUL is sign-agnostic in its low word.
  always_comb begin
    case (funct3)
      F3_MULH, F3_DIV, F3_REM: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      F3_MULHSU:               begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
      default:                 begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
    endcase
  end

  assign a_neg_s = a_signed_s & op_a[XLEN-1];
  assign b_neg_s = b_signed_s & op_b[XLEN-1];

  muldiv_negate #(.W(XLEN)) u_abs_a (.val_i(op_a), .neg_i(a_neg_s), .res_o(a_abs_s));
  muldiv_negate #(.W(XLEN)) u_abs_b (.val_i(op_b), .neg_i(b_neg_s), .res_o(b_abs_s));

  assign mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
  assign div_shift_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff_s  = div_shift_s - {1'b0, b_q};

  // One iteration: acc = {hi: partial product / remainder, lo: multiplier / dividend->quotient}.
  always_comb begin
    if (f3_q[2]) begin
      if (!div_diff_s[XLEN]) begin
        acc_d = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {div_shift_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      if (acc_q[0]) begin
        acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[2*XLEN-1:1]};
      end
    end
  end

  // Zero-extended 32-bit div values negate identically in the low word.
  always_comb begin
    if (!f3_q[2]) begin
      fix_val_s = acc_q;
    end else if (f3_q[1]) begin
      fix_val_s = {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]};
    end else begin
      fix_val_s = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
    end
  end

  muldiv_negate #(.W(2*XLEN)) u_fix (.val_i(fix_val_s), .neg_i(res_neg_q), .res_o(fix_neg_s));

  // Final result selection including the architectural special cases.
  always_comb begin
    case (f3_q)
      F3_MUL: result_d = fix_neg_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_d = fix_neg_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (div_zero_q) begin
          result_d = ALL_ONES;
        end else if (ovf_q) begin
          result_d = INT_MIN;
        end else begin
          result_d = fix_neg_s[XLEN-1:0];
        end
      end
      default: result_d = fix_neg_s[XLEN-1:0];
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      f3_q       <= 3'b000;
      b_q        <= {XLEN{1'b0}};
      acc_q      <= {(2*XLEN){1'b0}};
      res_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= {XLEN{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            state_q    <= CALC;
            busy_q     <= 1'b1;
            cnt_q      <= CNT_INIT;
            f3_q       <= funct3;
            b_q        <= b_abs_s;
            acc_q      <= {{XLEN{1'b0}}, a_abs_s};
            res_neg_q  <= (funct3[2] && funct3[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
            div_zero_q <= (op_b == {XLEN{1'b0}});
            ovf_q      <= (funct3 == F3_DIV) && (op_a == INT_MIN) && (op_b == ALL_ONES);
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!flush) begin
            result_q <= result_d;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed ops against a plain-arithmetic model.
module tb_muldiv_unit;

  logic        clk, rst_n, start, flush, busy, done;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] last_exp = 32'h0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: p = ua * ub;
      3'd1: begin p = sa * sb; p = p >>> 32; end
      3'd2: begin p = sa * ub; p = p >>> 32; end
      3'd3: begin p = ua * ub; p = p >> 32; end
      3'd4: begin
        if (b == 32'd0) p = 64'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'h8000_0000;
        else p = sa / sb;
      end
      3'd5: p = (b == 32'd0) ? 64'hFFFF_FFFF : ua / ub;
      3'd6: begin
        if (b == 32'd0) p = ua;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'd0;
        else p = sa % sb;
      end
      default: p = (b == 32'd0) ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Pulse start for one cycle; optionally enqueue the expected response.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    if (push) begin
      e.res = ref_model(f, a, b);
      e.cyc = cyc + 34;
      sb_q.push_back(e);
      last_exp = e.res;
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    issue(f, a, b, 1'b1);
    wait_idle(n);
    chk("busy_cycles", n, 32'd33);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done result=%h", result);
      end else begin
        e = sb_q.pop_front();
        if (result !== e.res) begin
          failures++;
          $display("FAIL result got=%h exp=%h", result, e.res);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL done_latency got_cycle=%0d exp_cycle=%0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'd6);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd4, 32'd5, 32'd0);
    run_op(3'd6, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFFB, 32'd0);

    // A second start mid-operation must not disturb the first.
    issue(3'd0, 32'd1234, 32'd5678, 1'b1);
    repeat (8) @(negedge clk);
    start = 1'b1; funct3 = 3'd5; op_a = 32'd99; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    chk("restart_idle", {31'd0, busy}, 32'd0);

    // Flush mid-operation: no done, result retained, then a normal op.
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (14) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_result", result, last_exp);
    repeat (40) @(negedge clk);
    chk("flush_result_hold", result, last_exp);
    run_op(3'd5, 32'd1000, 32'd10);

    // Flush together with start in IDLE: start is ignored.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_ignored", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-operation.
    issue(3'd4, 32'd77, 32'd7, 1'b0);
    repeat (18) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    last_exp = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midreset_no_done_result", result, 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
